// File: rtl/seq_shifter.sv
// Multi-cycle shifter: captures an operand on start, shifts one bit per clock,
// then pulses done with the result and the last bit shifted out.
module seq_shifter #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  in,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amt,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  sout,
    output logic          carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t        state;
    op_t           opl;
    logic [AW-1:0] count;
    logic [W-1:0]  stepsout;
    logic          stepcarry;

    // One-bit step of the working register for the latched operation
    always_comb begin
        stepsout  = sout;
        stepcarry = sout[0];
        case (opl)
            OP_LSL: begin
                stepcarry = sout[W-1];
                stepsout  = {sout[W-2:0], 1'b0};
            end
            OP_LSR: stepsout = {1'b0, sout[W-1:1]};
            OP_ASR: stepsout = {sout[W-1], sout[W-1:1]};
            OP_ROR: stepsout = {sout[0], sout[W-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            opl   <= OP_LSL;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sout  <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sout  <= in;
                        count <= amt;
                        opl   <= op_t'(op);
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        sout  <= stepsout;
                        carry <= stepcarry;
                        count <= count - 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Result stays on sout/carry while idle until the next start
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter; expected results come from an
// arithmetic reference model and are checked by a scoreboard monitor.
module tb_seq_shifter;

    localparam int W  = 16;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  din;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic          busy;
    logic          done;
    logic [W-1:0]  sout;
    logic          carry;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    exp_t q[$];
    exp_t held;
    int   lastDone  = -10;
    bit   postCheck = 1'b0;

    seq_shifter #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (din),
        .op    (op),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .sout  (sout),
        .carry (carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference result computed directly from the shift definitions
    function automatic void refModel(input logic [W-1:0] a, input logic [1:0] o, input int n,
                                     output logic [W-1:0] r, output logic c);
        int k;
        r = a;
        c = 1'b0;
        if (n != 0) begin
            case (o)
                2'b00: begin
                    r = (n >= W) ? '0 : W'(a << n);
                    c = (n <= W) ? a[W-n] : 1'b0;
                end
                2'b01: begin
                    r = (n >= W) ? '0 : W'(a >> n);
                    c = (n <= W) ? a[n-1] : 1'b0;
                end
                2'b10: begin
                    r = (n >= W) ? {W{a[W-1]}} : W'($signed(a) >>> n);
                    c = (n <= W) ? a[n-1] : a[W-1];
                end
                default: begin
                    k = n % W;
                    r = (k == 0) ? a : W'((a >> k) | (a << (W - k)));
                    c = a[(n - 1) % W];
                end
            endcase
        end
    endfunction

    // Caller must be at a negedge; returns at the negedge after acceptance
    task automatic applyStimulus(input logic [W-1:0] a, input logic [1:0] o, input int n, input bit push);
        int   waitCount = 0;
        exp_t e;
        while (busy !== 1'b0 && waitCount < 200) begin
            @(negedge clk);
            waitCount++;
        end
        if (waitCount >= 200) checkOutput("idle_wait", 32'(busy), 32'd0);
        din   = a;
        op    = o;
        amt   = AW'(n);
        start = 1'b1;
        if (push) begin
            refModel(a, o, n, e.s, e.c);
            e.t = cycle + n + 2;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Scoreboard monitor: compares every done pulse with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (postCheck && cycle == lastDone + 1) begin
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("busy_after_done", 32'(busy), 32'd0);
            checkOutput("sout_hold", 32'(sout), 32'(held.s));
            checkOutput("carry_hold", 32'(carry), 32'(held.c));
            postCheck = 1'b0;
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                checkOutput("sout", 32'(sout), 32'(e.s));
                checkOutput("carry", 32'(carry), 32'(e.c));
                checkOutput("done_cycle", 32'(cycle), 32'(e.t));
                held      = e;
                lastDone  = cycle;
                postCheck = 1'b1;
            end
        end
    end

    initial begin
        int waitCount;
        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        op    = '0;
        amt   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sout", 32'(sout), 32'd0);
        checkOutput("reset_carry", 32'(carry), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(16'h8001, 2'b00, 1, 1'b1);
        applyStimulus(16'h8000, 2'b10, 4, 1'b1);
        applyStimulus(16'h1234, 2'b11, 4, 1'b1);
        applyStimulus(16'h1234, 2'b11, 15, 1'b1);
        applyStimulus(16'hABCD, 2'b01, 0, 1'b1);
        applyStimulus(16'hFFFF, 2'b00, 15, 1'b1);

        // A start pulse with a different operand during SHIFT must be ignored
        applyStimulus(16'h00F0, 2'b01, 8, 1'b1);
        @(negedge clk);
        din   = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Abort an operation with reset; no done pulse may follow
        applyStimulus(16'h00F0, 2'b01, 8, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sout", 32'(sout), 32'd0);
        checkOutput("abort_carry", 32'(carry), 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("abort_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(W'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, (1 << AW) - 1), 1'b1);
        end

        waitCount = 0;
        while (q.size() != 0 && waitCount < 200) begin
            @(negedge clk);
            waitCount++;
        end
        checkOutput("scoreboard_drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
